// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous instruction memory
// and streams {pc, ir} beats to decode. Define FETCH_PERF_EN to add perf_fetched/perf_flushed.
module fetch #(
   parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
   parameter int          IMEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall,
   input  logic        bubble,
   input  logic        jump_tvalid,
   input  logic [31:0] jump_tdata,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        decode_tvalid,
   input  logic        decode_tready,
   output logic [63:0] decode_tdata,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed,
`endif
   output logic [1:0]  dbg_state
);

   if (IMEM_LATENCY != 1) begin : g_latency_check
      $error("fetch: only IMEM_LATENCY=1 is supported");
   end

   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        a_v_q, a_v_d;
   logic [63:0] a_data_q, a_data_d;
   logic        b_v_q, b_v_d;
   logic [63:0] b_data_q, b_data_d;
   logic        drop, live_v, accept, issue;
   logic [63:0] live_data;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= BOOT;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (!jump_tvalid && bubble) state_d = FLUSH;
         FLUSH:   if (jump_tvalid) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   // A request is only issued if its response is guaranteed a slot: skid empty after this cycle.
   always_comb begin
      issue     = (state_q == RUN) & ~stall & ~bubble & ~jump_tvalid & ~b_v_d;
      imem_en   = issue;
      imem_addr = pc_q;
      dbg_state = state_q;
   end

   // Handshake: a beat transfers when decode_tvalid & decode_tready at a rising edge; an
   // unaccepted beat is parked in a_* and re-presented unchanged until it transfers.
   always_comb begin
      drop          = jump_tvalid | (state_q == FLUSH) | ((state_q == RUN) & bubble);
      live_v        = req_q & ~drop;
      live_data     = {req_pc_q, imem_rdata};
      decode_tvalid = a_v_q | live_v;
      decode_tdata  = a_v_q ? a_data_q : (live_v ? live_data : 64'd0);
      accept        = decode_tvalid & decode_tready;
      a_v_d         = a_v_q;
      a_data_d      = a_data_q;
      b_v_d         = b_v_q;
      b_data_d      = b_data_q;
      if (a_v_q) begin
         if (accept) begin
            a_v_d    = b_v_q | live_v;
            a_data_d = b_v_q ? b_data_q : live_data;
            b_v_d    = b_v_q & live_v;
            b_data_d = live_data;
         end else if (!b_v_q) begin
            b_v_d    = live_v;
            b_data_d = live_data;
         end
      end else begin
         a_v_d    = live_v & ~accept;
         a_data_d = live_data;
      end
   end

   always_comb begin
      pc_d     = pc_q;
      req_d    = issue;
      req_pc_d = req_pc_q;
      if (jump_tvalid) begin
         pc_d = jump_tdata & 32'hFFFF_FFFC;
      end else if (issue) begin
         pc_d = pc_q + 32'd4;
      end
      if (issue) req_pc_d = pc_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_q     <= RESET_ADDR;
         req_q    <= 1'b0;
         req_pc_q <= RESET_ADDR;
         a_v_q    <= 1'b0;
         a_data_q <= 64'd0;
         b_v_q    <= 1'b0;
         b_data_q <= 64'd0;
      end else begin
         pc_q     <= pc_d;
         req_q    <= req_d;
         req_pc_q <= req_pc_d;
         a_v_q    <= a_v_d;
         a_data_q <= a_data_d;
         b_v_q    <= b_v_d;
         b_data_q <= b_data_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_flushed_q, perf_flushed_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + {31'd0, accept};
      perf_flushed_d = perf_flushed_q + {31'd0, req_q & drop};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_fetched_q <= 32'd0;
         perf_flushed_q <= 32'd0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_flushed_q <= perf_flushed_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch stage of the rv32 pipeline; sits directly upstream of decode.
- Owns the program counter and drives a synchronous instruction memory.
- Presents {pc, ir} beats to decode over an AXI-stream style handshake.
- Obeys the stall and bubble controls produced by the hazard unit, and is redirected by jump/branch resolution from execute.

Parameters:
- RESET_ADDR, 32'h0000_0000, first PC fetched after reset.
- IMEM_LATENCY, 1, instruction memory read latency in cycles. Only the value 1 is supported; any other value is an elaboration error.

Ports:
- clk  input  1  core clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- stall  input  1  hazard stall; hold the current output beat, issue nothing new.
- bubble  input  1  hazard bubble; control transfer now in decode, enter FLUSH.
- jump_tvalid  input  1  execute resolved a control transfer (taken or not) this cycle.
- jump_tdata  input  32  next PC after the control transfer (target, or pc+4 if not taken).
- imem_en  output  1  instruction memory read enable.
- imem_addr  output  32  instruction memory word address (byte address, [1:0]=0).
- imem_rdata  input  32  instruction word, valid one cycle after an imem_en cycle.
- decode_tvalid  output  1  beat valid toward decode.
- decode_tready  input  1  decode accepts the beat.
- decode_tdata  output  64  {pc[63:32], ir[31:0]}.

Behaviour:
- Reset values: pc=RESET_ADDR; state=BOOT; imem_en=0; imem_addr=RESET_ADDR; decode_tvalid=0; decode_tdata=0; skid buffer empty.
- States: BOOT, RUN, FLUSH.
  - BOOT: one cycle after reset release, then RUN. No request is issued in BOOT.
  - RUN:
    - Issue request when (no stall) and (skid empty or decode_tready): imem_en=1, imem_addr=pc, pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
    - Response appears one cycle later as {issued pc, imem_rdata}.
  - FLUSH:
    - Entered on bubble=1 in RUN.
    - The in-flight response, if any, is discarded: decode_tvalid=0 for its cycle. It is a speculative fetch past the control instruction.
    - No new requests while in FLUSH.
    - On jump_tvalid: pc<=jump_tdata, state<=RUN; the first request to jump_tdata is issued the following cycle.
- jump_tvalid in RUN (no prior bubble): treated identically. Redirect the PC, drop any in-flight response.
- jump_tvalid and bubble in the same cycle: jump wins; state=RUN, pc=jump_tdata, bubble ignored.
- jump_tdata[1:0]!=0: bits forced to 0 (no misalignment trap in this block).
- Handshake:
  - decode_tvalid, once high, holds with decode_tdata stable until decode_tready=1 in the same cycle.
  - Not a combinational path from decode_tready to decode_tvalid.
- Skid:
  - A response arriving while the output beat is held is captured in a one-entry skid register.
  - The request that would overflow the skid is never issued.
  - Skid drains before new responses are presented; order is preserved.
- stall=1:
  - No imem_en.
  - pc holds.
  - The current output beat holds (decode_tvalid unchanged).
  - The in-flight response lands in skid.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Pending responses are discarded.
- Throughput: 1 instruction/cycle in RUN with decode_tready=1 and stall=0. Latency from request to decode_tvalid is 1 cycle.

Optional Feature:
- Macro FETCH_PERF_EN adds two output ports: perf_fetched (32) and perf_flushed (32).
- perf_fetched counts beats accepted by decode (tvalid&tready).
- perf_flushed counts responses discarded by flush or redirect.
- Both counters reset to 0 and wrap at 2^32.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_ADDR=0x100, tready=1, memory returns addr^0xA5A5_0000 -> beats pc=0x100,0x104,0x108 on consecutive cycles, starting 2 cycles after resetn rises.
- decode_tready low 3 cycles mid-stream -> held beat unchanged; skid captures the next word; no pc skipped or duplicated once tready returns.
- bubble at pc=0x10C in decode, jump_tvalid 2 cycles later with jump_tdata=0x200 -> 0x110 response dropped; next beat pc=0x200.
- stall high 4 cycles -> imem_en=0 throughout, pc constant, decode_tvalid held; stream resumes at the correct next pc.
- jump_tvalid and bubble in the same cycle, jump_tdata=0x0000_0042 -> next beat pc=0x40, state RUN.
- resetn dropped mid-FLUSH -> outputs return to reset values immediately; restart from RESET_ADDR. With FETCH_PERF_EN, counters read 0.
